// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
// ----------------
// Parametrised transition-register chain carrying one payload word per
// instruction from decode to writeback. Every stage has a valid bit. One
// stall freezes the whole chain. A flush squashes the FLUSH_DEPTH youngest
// stages and drops the incoming payload.
//
// Parameters:
//   WIDTH        payload width per stage
//   STAGES       chain depth (2..8)
//   FLUSH_DEPTH  number of youngest stages cleared by flush (1..STAGES)
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid, in_data payload presented to stage 0
//   in_ready          ~stall
//   stall             freeze every stage
//   flush             squash stages 0..FLUSH_DEPTH-1 and the incoming payload
//   stage_valid       per-stage valid bits, bit 0 = youngest
//   stage_data        flattened payloads, stage k at [k*WIDTH +: WIDTH]
//   out_valid         valid of the oldest stage, qualified by ~stall
//   out_data          payload of the oldest stage
//   occupancy         registered count of set stage_valid bits
//   stall_cycles      (PIPE_STAGE_CHAIN_PERF_EN only) stalled-cycle counter
//   squash_count      (PIPE_STAGE_CHAIN_PERF_EN only) valid bits cleared by flush
//
// Optional feature macro: PIPE_STAGE_CHAIN_PERF_EN adds the two 32-bit
// wrapping performance counters. When it is undefined, the ports are absent.

module pipe_stage_chain #(
  parameter int WIDTH       = 16,
  parameter int STAGES      = 4,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  input  logic                          stall,
  input  logic                          flush,
  output logic [STAGES-1:0]             stage_valid,
  output logic [STAGES*WIDTH-1:0]       stage_data,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  output logic [31:0]                   stall_cycles,
  output logic [31:0]                   squash_count,
`endif
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(STAGES + 1);

  // Bits 0..FLUSH_DEPTH-1 set: the stages a flush squashes.
  localparam logic [STAGES-1:0] FLUSH_MASK = {STAGES{1'b1}} >> (STAGES - FLUSH_DEPTH);

  // Population count of a valid vector.
  function automatic logic [OCC_W-1:0] count_ones(input logic [STAGES-1:0] v);
    logic [OCC_W-1:0] n;
    n = '0;
    for (int k = 0; k < STAGES; k++) begin
      n = n + {{(OCC_W-1){1'b0}}, v[k]};
    end
    return n;
  endfunction

  logic [STAGES-1:0]       valid_q, valid_d;
  logic [STAGES*WIDTH-1:0] data_q, data_d;
  logic [OCC_W-1:0]        occupancy_q, occupancy_d;
  logic [STAGES-1:0]       shift_valid;  // next valid vector before flush masking
  logic [STAGES-1:0]       squashed;     // valid bits the flush removes this cycle

  // Next-state: shift or hold, then mask the flushed stages.
  always_comb begin
    shift_valid = valid_q;
    data_d      = data_q;
    if (stall) begin
      shift_valid = valid_q;
      data_d      = data_q;
    end else begin
      // Invalid payloads shift as well; only the valid bit qualifies them.
      shift_valid = {valid_q[STAGES-2:0], in_valid};
      data_d      = {data_q[(STAGES-1)*WIDTH-1:0], in_data};
    end
    if (flush) begin
      // Flush wins over hold for the young stages, whether stalled or not.
      valid_d  = shift_valid & ~FLUSH_MASK;
      squashed = shift_valid & FLUSH_MASK;
    end else begin
      valid_d  = shift_valid;
      squashed = '0;
    end
    // Derived from the next valid vector so the count never lags stage_valid.
    occupancy_d = count_ones(valid_d);
  end

  // Chain state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= '0;
      data_q      <= '0;
      occupancy_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      occupancy_q <= occupancy_d;
    end
  end

`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] squash_count_q, squash_count_d;

  // Counter next-state; both wrap naturally at 32 bits.
  always_comb begin
    if (stall) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
    squash_count_d = squash_count_q + {{(32-OCC_W){1'b0}}, count_ones(squashed)};
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 32'd0;
      squash_count_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      squash_count_q <= squash_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign squash_count = squash_count_q;
`endif

  assign stage_valid = valid_q;
  assign stage_data  = data_q;
  assign out_data    = data_q[(STAGES-1)*WIDTH +: WIDTH];
  assign occupancy   = occupancy_q;
  assign in_ready    = ~stall;
  // Suppressed while stalled so the consumer fires exactly once per instruction.
  assign out_valid   = valid_q[STAGES-1] & ~stall;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed testbench for pipe_stage_chain (WIDTH=16, STAGES=4, FLUSH_DEPTH=2).
// A stage-array model is advanced on every clock edge using the chain's
// behavioural rules. The DUT is compared against it on every falling edge.
// Hand-computed literal expectations pin the model at key points.

module tb_pipe_stage_chain;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int FD = 2;

  logic           clk = 1'b0;
  logic           reset, in_valid, stall, flush;
  logic [W-1:0]   in_data;
  logic           in_ready, out_valid;
  logic [S-1:0]   stage_valid;
  logic [S*W-1:0] stage_data;
  logic [W-1:0]   out_data;
  logic [2:0]     occupancy;
`ifdef PIPE_STAGE_CHAIN_PERF_EN
  logic [31:0]    stall_cycles, squash_count;
  int unsigned    m_stall, m_squash;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Model: per-stage valid, payload, and whether the payload is defined.
  logic         m_v [S];
  logic [W-1:0] m_d [S];
  logic         m_k [S];

  always #5 clk = ~clk;

  pipe_stage_chain #(.WIDTH(W), .STAGES(S), .FLUSH_DEPTH(FD)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .stall       (stall),
    .flush       (flush),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    .stall_cycles(stall_cycles),
    .squash_count(squash_count),
`endif
    .occupancy   (occupancy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock edge of the behavioural model, applied with the current inputs.
  task automatic model_edge();
    if (reset) begin
      for (int k = 0; k < S; k++) begin
        m_v[k] = 1'b0; m_d[k] = '0; m_k[k] = 1'b1;
      end
`ifdef PIPE_STAGE_CHAIN_PERF_EN
      m_stall = 0; m_squash = 0;
`endif
    end else if (stall) begin
`ifdef PIPE_STAGE_CHAIN_PERF_EN
      m_stall++;
`endif
      if (flush) begin
        for (int k = 0; k < FD; k++) begin
`ifdef PIPE_STAGE_CHAIN_PERF_EN
          if (m_v[k]) m_squash++;
`endif
          m_v[k] = 1'b0;
        end
      end
    end else begin
      for (int k = S - 1; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_d[k] = m_d[k-1]; m_k[k] = m_k[k-1];
      end
      m_v[0] = in_valid; m_d[0] = in_data; m_k[0] = 1'b1;
      if (flush) begin
        for (int k = 0; k < FD; k++) begin
`ifdef PIPE_STAGE_CHAIN_PERF_EN
          if (m_v[k]) m_squash++;
`endif
          m_v[k] = 1'b0; m_k[k] = 1'b0;
        end
      end
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    logic [S-1:0] ev;
    int           cnt;
    cnt = 0;
    for (int k = 0; k < S; k++) begin
      ev[k] = m_v[k];
      cnt   = cnt + (m_v[k] ? 1 : 0);
    end
    check("stage_valid", {60'd0, stage_valid}, {60'd0, ev});
    check("occupancy", {61'd0, occupancy}, 64'(cnt));
    check("out_valid", {63'd0, out_valid}, {63'd0, m_v[S-1] & ~stall});
    check("in_ready", {63'd0, in_ready}, {63'd0, ~stall});
    for (int k = 0; k < S; k++) begin
      if (m_k[k]) check($sformatf("stage_data[%0d]", k), {48'd0, stage_data[k*W +: W]}, {48'd0, m_d[k]});
    end
    if (m_k[S-1]) check("out_data", {48'd0, out_data}, {48'd0, m_d[S-1]});
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    check("stall_cycles", {32'd0, stall_cycles}, {32'd0, m_stall});
    check("squash_count", {32'd0, squash_count}, {32'd0, m_squash});
`endif
  endtask

  // Drive one cycle of inputs, clock it, then compare at the falling edge.
  task automatic cyc(input logic r, input logic v, input logic [W-1:0] d,
                     input logic s, input logic f);
    reset = r; in_valid = v; in_data = d; stall = s; flush = f;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  logic [W-1:0] rel_exp [4];

  initial begin
    rel_exp = '{16'h0002, 16'h0003, 16'h0004, 16'h00A0};
    for (int k = 0; k < S; k++) begin
      m_v[k] = 1'b0; m_d[k] = '0; m_k[k] = 1'b0;
    end
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    m_stall = 0; m_squash = 0;
`endif

    // Reset
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("rst_valid", {60'd0, stage_valid}, 64'h0);
    check("rst_data", stage_data, 64'h0);
    check("rst_occ", {61'd0, occupancy}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Fill with 1..4
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 1'b1, 16'(i), 1'b0, 1'b0);
      check("fill_occ", {61'd0, occupancy}, 64'(i));
      if (i == 3) check("fill_no_out_yet", {63'd0, out_valid}, 64'd0);
    end
    check("fill_out_valid", {63'd0, out_valid}, 64'd1);
    check("fill_out_data", {48'd0, out_data}, 64'h0001);

    // Stall 3 cycles with a full chain
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 16'h00A0, 1'b1, 1'b0);
      check("stall_data", stage_data, 64'h0001_0002_0003_0004);
      check("stall_valid", {60'd0, stage_valid}, 64'hF);
      check("stall_out_valid", {63'd0, out_valid}, 64'd0);
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    check("perf_stall_3", {32'd0, stall_cycles}, 64'd3);
`endif

    // Release: one payload per cycle, no duplicates; load A0..A3
    for (int j = 0; j < 4; j++) begin
      cyc(1'b0, 1'b1, 16'h00A0 + 16'(j), 1'b0, 1'b0);
      check("release_out", {48'd0, out_data}, {48'd0, rel_exp[j]});
    end
    check("full_a_data", stage_data, 64'h00A0_00A1_00A2_00A3);

    // Flush while advancing
    cyc(1'b0, 1'b1, 16'h00A4, 1'b0, 1'b1);
    check("flush_adv_valid", {60'd0, stage_valid}, 64'b1100);
    check("flush_adv_occ", {61'd0, occupancy}, 64'd2);
    check("flush_adv_old", {32'd0, stage_data[63:32]}, 64'h00A1_00A2);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    check("perf_flush1_stall", {32'd0, stall_cycles}, 64'd3);
    check("perf_flush1_squash", {32'd0, squash_count}, 64'd2);
`endif

    // Refill with B0..B3
    for (int j = 0; j < 4; j++) cyc(1'b0, 1'b1, 16'h00B0 + 16'(j), 1'b0, 1'b0);
    check("refill_valid", {60'd0, stage_valid}, 64'hF);

    // Flush during stall
    cyc(1'b0, 1'b1, 16'h00C0, 1'b1, 1'b1);
    check("flush_stall_valid", {60'd0, stage_valid}, 64'b1100);
    check("flush_stall_data", stage_data, 64'h00B0_00B1_00B2_00B3);
    check("flush_stall_occ", {61'd0, occupancy}, 64'd2);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    check("perf_flush2_stall", {32'd0, stall_cycles}, 64'd4);
    check("perf_flush2_squash", {32'd0, squash_count}, 64'd4);
`endif

    // Advance C0, C1
    cyc(1'b0, 1'b1, 16'h00C0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'h00C1, 1'b0, 1'b0);
    check("adv_c_valid", {60'd0, stage_valid}, 64'b0011);

    // Held flush keeps the flushed stages empty
    cyc(1'b0, 1'b1, 16'h00D0, 1'b0, 1'b1);
    check("hold_flush1_valid", {60'd0, stage_valid}, 64'b0100);
    cyc(1'b0, 1'b1, 16'h00D1, 1'b0, 1'b1);
    check("hold_flush2_valid", {60'd0, stage_valid}, 64'b1000);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    check("perf_hold_squash", {32'd0, squash_count}, 64'd7);
`endif

    // Half-fill, then reset together with stall and flush
    cyc(1'b0, 1'b1, 16'h00E0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'h00E1, 1'b0, 1'b0);
    check("half_occ", {61'd0, occupancy}, 64'd2);
    cyc(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    check("midrst_valid", {60'd0, stage_valid}, 64'h0);
    check("midrst_data", stage_data, 64'h0);
    check("midrst_occ", {61'd0, occupancy}, 64'd0);
`ifdef PIPE_STAGE_CHAIN_PERF_EN
    check("midrst_stall_cnt", {32'd0, stall_cycles}, 64'd0);
    check("midrst_squash_cnt", {32'd0, squash_count}, 64'd0);
`endif

    // Resume and drain
    cyc(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
    check("resume_valid", {60'd0, stage_valid}, 64'b0001);
    check("resume_data", {48'd0, stage_data[15:0]}, 64'h1234);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check("drain_occ", {61'd0, occupancy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
